// File: rtl/pending_write_drain_if.sv
// Pending-write drain bus: FIFO read side, VRAM write side and status.
// master = drain stage, slave = FIFO/video environment.
interface pending_write_drain_if #(
    parameter int ADDR_WIDTH = 17
);
    logic [2:0]            clockPhase;
    logic                  pendingWriteQueueReadEmpty;
    logic [24:0]           pendingWriteQueueReadBus;
    logic                  pendingWriteQueueReadRequest;
    logic                  writeAllowed;
    logic [ADDR_WIDTH-1:0] vramAddress;
    logic [7:0]            vramData;
    logic                  vramWriteEnable;
    logic                  busy;

    modport master (
        input  clockPhase,
        input  pendingWriteQueueReadEmpty,
        input  pendingWriteQueueReadBus,
        input  writeAllowed,
        output pendingWriteQueueReadRequest,
        output vramAddress,
        output vramData,
        output vramWriteEnable,
        output busy
    );

    modport slave (
        output clockPhase,
        output pendingWriteQueueReadEmpty,
        output pendingWriteQueueReadBus,
        output writeAllowed,
        input  pendingWriteQueueReadRequest,
        input  vramAddress,
        input  vramData,
        input  vramWriteEnable,
        input  busy
    );
endinterface

// File: rtl/pending_write_drain.sv
// Drains pending-write FIFO entries into 320x240 VRAM writes in the write phase.
// Optional DRAIN_STATS_EN adds writeCount/dropCount outputs.
module pending_write_drain #(
    parameter logic [2:0] WRITE_PHASE = 3'd5,
    parameter int         H_RES       = 320,
    parameter int         V_RES       = 240,
    parameter int         ADDR_WIDTH  = 17
) (
    input  logic                  clock,
    input  logic                  reset,
    pending_write_drain_if.master bus
`ifdef DRAIN_STATS_EN
    ,
    output logic [15:0]           writeCount,
    output logic [15:0]           dropCount
`endif
);
    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        FETCH,
        CALC,
        WAIT_SLOT,
        WRITE
    } state_t;

    localparam logic [8:0] H_LIM = 9'(H_RES);
    localparam logic [8:0] V_LIM = 9'(V_RES);

    state_t                state;
    state_t                next;
    logic [7:0]            y_q;
    logic [8:0]            x_q;
    logic [7:0]            data_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_calc;
    logic                  in_range;

    assign in_range  = (x_q < H_LIM) && ({1'b0, y_q} < V_LIM);
    // y*320 as shift-add, full width so (319,239) lands on 76799
    assign addr_calc = (ADDR_WIDTH'(y_q) << 8)
                     + (ADDR_WIDTH'(y_q) << 6)
                     + ADDR_WIDTH'(x_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            y_q    <= '0;
            x_q    <= '0;
            data_q <= '0;
            addr_q <= '0;
        end else begin
            state <= next;
            if (state == FETCH)
                {y_q, x_q, data_q} <= bus.pendingWriteQueueReadBus;
            if (state == CALC && in_range)
                addr_q <= addr_calc;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:
                if (!bus.pendingWriteQueueReadEmpty)
                    next = REQUEST;
            REQUEST:
                next = FETCH;
            FETCH:
                next = CALC;
            CALC:
                next = in_range ? WAIT_SLOT : IDLE;
            WAIT_SLOT:
                if (bus.clockPhase == WRITE_PHASE && bus.writeAllowed)
                    next = WRITE;
            WRITE:
                next = IDLE;
            default:
                next = IDLE;
        endcase
    end

    assign bus.pendingWriteQueueReadRequest = (state == REQUEST);
    assign bus.vramWriteEnable              = (state == WRITE);
    assign bus.busy                         = (state != IDLE);
    assign bus.vramAddress                  = addr_q;
    assign bus.vramData                     = data_q;

`ifdef DRAIN_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            writeCount <= '0;
            dropCount  <= '0;
        end else begin
            if (state == WRITE)
                writeCount <= writeCount + 16'd1;
            if (state == CALC && !in_range)
                dropCount <= dropCount + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pending_write_drain.sv
// Self-checking bench for pending_write_drain: FIFO model, scoreboard,
// vector table and hand-written multi-cycle sequences.
module tb_pending_write_drain;
    logic clock = 1'b0;
    logic reset = 1'b1;

    pending_write_drain_if bus ();

`ifdef DRAIN_STATS_EN
    logic [15:0] writeCount;
    logic [15:0] dropCount;
`endif

    pending_write_drain dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus)
`ifdef DRAIN_STATS_EN
        ,
        .writeCount (writeCount),
        .dropCount  (dropCount)
`endif
    );

    always #5 clock = ~clock;

    logic [2:0]  phase = 3'd0;
    logic        allowed = 1'b0;
    logic [24:0] fifo_q = '0;
    int          pushed = 0;
    int          popped = 0;
    logic [24:0] fifo[$];
    logic [24:0] exp_q[$];

    assign bus.clockPhase                 = phase;
    assign bus.writeAllowed               = allowed;
    assign bus.pendingWriteQueueReadBus   = fifo_q;
    assign bus.pendingWriteQueueReadEmpty = (pushed == popped);

    int vectors = 0;
    int miscompares = 0;
    int strobes = 0;
    int rdreqs = 0;
    logic [2:0] prev_phase = 3'd0;
    logic       prev_allowed = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Clock phase counter and the FIFO read side (normal mode)
    always @(posedge clock) begin
        phase        <= phase + 3'd1;
        prev_phase   <= phase;
        prev_allowed <= allowed;
        if (!reset && bus.pendingWriteQueueReadRequest) begin
            check("rdreq_while_empty", int'(pushed != popped), 1);
            if (fifo.size() > 0) begin
                fifo_q <= fifo.pop_front();
                popped <= popped + 1;
            end
        end
    end

    // Scoreboard: compare each strobe against the oldest expected write
    always @(negedge clock) begin
        if (!reset && bus.pendingWriteQueueReadRequest)
            rdreqs++;
        if (!reset && bus.vramWriteEnable) begin
            logic [24:0] e;
            strobes++;
            check("grant_phase", int'(prev_phase), 5);
            check("grant_allowed", int'(prev_allowed), 1);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", int'(bus.vramAddress), int'(e[24:8]));
                check("wr_data", int'(bus.vramData), int'(e[7:0]));
            end
        end
    end

    task automatic push_entry(input logic [7:0] y, input logic [8:0] x,
                              input logic [7:0] d, input bit wr,
                              input logic [16:0] addr);
        fifo.push_back({y, x, d});
        pushed++;
        if (wr)
            exp_q.push_back({addr, d});
    endtask

    task automatic wait_drain();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((pushed != popped || bus.busy) && n < 300);
        if (n >= 300)
            check("drain_timeout", 0, 1);
    endtask

    typedef struct {
        logic [7:0]  y;
        logic [8:0]  x;
        logic [7:0]  d;
        bit          wr;
        logic [16:0] addr;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int s0;
        int r0;
        int bad;
        int n;
        int nwr;
        int ndrop;

        vecs[0] = '{8'd0,   9'd0,   8'hAA, 1'b1, 17'd0};
        vecs[1] = '{8'd239, 9'd319, 8'h3C, 1'b1, 17'd76799};
        vecs[2] = '{8'd10,  9'd320, 8'hFF, 1'b0, 17'd0};
        vecs[3] = '{8'd240, 9'd5,   8'h11, 1'b0, 17'd0};
        vecs[4] = '{8'd0,   9'd319, 8'h55, 1'b1, 17'd319};
        vecs[5] = '{8'd1,   9'd0,   8'h01, 1'b1, 17'd320};
        vecs[6] = '{8'd239, 9'd0,   8'hC3, 1'b1, 17'd76480};
        vecs[7] = '{8'd100, 9'd200, 8'h7E, 1'b1, 17'd32200};
        vecs[8] = '{8'd255, 9'd511, 8'h99, 1'b0, 17'd0};
        vecs[9] = '{8'd5,   9'd7,   8'h42, 1'b1, 17'd1607};

        repeat (3) @(negedge clock);
        check("rst_rdreq", int'(bus.pendingWriteQueueReadRequest), 0);
        check("rst_we", int'(bus.vramWriteEnable), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_addr", int'(bus.vramAddress), 0);
        check("rst_data", int'(bus.vramData), 0);
        reset = 1'b0;
        allowed = 1'b1;

        nwr = 0;
        ndrop = 0;
        for (int i = 0; i < 10; i++) begin
            s0 = strobes;
            push_entry(vecs[i].y, vecs[i].x, vecs[i].d, vecs[i].wr,
                       vecs[i].addr);
            wait_drain();
            check($sformatf("vec%0d_strobes", i), strobes - s0,
                  int'(vecs[i].wr));
            if (vecs[i].wr) nwr++;
            else ndrop++;
        end
`ifdef DRAIN_STATS_EN
        check("stat_writes", int'(writeCount), nwr);
        check("stat_drops", int'(dropCount), ndrop);
`endif

        // Three queued entries held off by writeAllowed
        allowed = 1'b0;
        s0 = strobes;
        r0 = rdreqs;
        push_entry(8'd2,  9'd3,   8'hA1, 1'b1, 17'd643);
        push_entry(8'd50, 9'd100, 8'hB2, 1'b1, 17'd16100);
        push_entry(8'd3,  9'd318, 8'hC3, 1'b1, 17'd1278);
        repeat (20) @(negedge clock);
        check("hold_no_strobe", strobes - s0, 0);
        check("hold_busy", int'(bus.busy), 1);
        allowed = 1'b1;
        wait_drain();
        check("queued_strobes", strobes - s0, 3);
        check("queued_rdreqs", rdreqs - r0, 3);
        check("queued_sb_empty", exp_q.size(), 0);

        // Idle with empty FIFO
        bad = 0;
        repeat (50) begin
            @(negedge clock);
            if (bus.pendingWriteQueueReadRequest || bus.busy ||
                bus.vramWriteEnable)
                bad++;
        end
        check("idle_quiet", bad, 0);

        // Reset while waiting for a slot: first entry lost, second written
        allowed = 1'b0;
        push_entry(8'd20, 9'd20, 8'hDE, 1'b0, 17'd0);
        push_entry(8'd30, 9'd40, 8'hEF, 1'b1, 17'd9640);
        n = 0;
        while (pushed - popped != 1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("first_pop_seen", pushed - popped, 1);
        repeat (6) @(negedge clock);
        check("pre_rst_busy", int'(bus.busy), 1);
        s0 = strobes;
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_we", int'(bus.vramWriteEnable), 0);
        check("mid_rst_rdreq", int'(bus.pendingWriteQueueReadRequest), 0);
        check("mid_rst_addr", int'(bus.vramAddress), 0);
        check("mid_rst_data", int'(bus.vramData), 0);
`ifdef DRAIN_STATS_EN
        check("mid_rst_wcount", int'(writeCount), 0);
        check("mid_rst_dcount", int'(dropCount), 0);
`endif
        reset = 1'b0;
        allowed = 1'b1;
        wait_drain();
        check("post_rst_strobes", strobes - s0, 1);
        check("post_rst_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
